// File: rtl/udp_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : udp_tx_framer
// Description : Builds one Ethernet/IPv4/UDP frame per command and streams it
//               out as AXI-Stream bytes. The UDP payload is AA 55 LEN DATA CHK,
//               where CHK is the XOR of the DATA bytes. A short payload is
//               zero-padded up to LEN; an over-long payload is truncated and
//               the excess is drained up to its tlast.
//               Optional macro UDP_TX_IP_CSUM_EN fills in the IPv4 header
//               checksum; without it that field is sent as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module udp_tx_framer #(
    parameter logic [47:0] SRC_MAC  = 48'h02_00_00_00_00_01,
    parameter logic [47:0] DST_MAC  = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [31:0] SRC_IP   = 32'hC0A8_0001,
    parameter logic [31:0] DST_IP   = 32'hC0A8_0002,
    parameter logic [15:0] SRC_PORT = 16'h04D2,
    parameter logic [7:0]  TTL      = 8'h40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_len,
    input  logic [15:0] cmd_dst_port,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic        frame_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_PAY   = 3'd2;
    localparam logic [2:0] S_PAD   = 3'd3;
    localparam logic [2:0] S_CHK   = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;

    // Index of the LEN byte, the last byte produced by the header counter.
    localparam logic [5:0] c_LAST_HDR = 6'd44;
    localparam logic [8:0] c_HDR_MSB  = 9'd359;

    logic [2:0]   r_state;
    logic [5:0]   r_cnt;        // next header byte to emit
    logic [7:0]   r_len;
    logic [15:0]  r_dst_port;
    logic [7:0]   r_pay_cnt;    // data bytes emitted so far (payload + pad)
    logic [7:0]   r_chk;
    logic         r_drain;      // payload overran LEN; discard rest after CHK
    logic         r_chk_sent;   // CHK byte sits in the output register
    logic [7:0]   r_tdata;
    logic         r_tvalid;
    logic         r_tlast;

    logic         w_load;
    logic         w_pay_acc;
    logic [7:0]   w_pay_k;
    logic [15:0]  w_tot_len;
    logic [15:0]  w_udp_len;
    logic [15:0]  w_csum;
    logic [359:0] w_hdr;
    logic [8:0]   w_bit_idx;
    logic [7:0]   w_hdr_byte;

    // Output slice may take a new byte when empty or being drained this cycle.
    assign w_load        = !r_tvalid || m_axis_tready;
    assign cmd_ready     = (r_state == S_IDLE);
    assign s_axis_tready = ((r_state == S_PAY) && w_load) || (r_state == S_DRAIN);
    assign w_pay_acc     = (r_state == S_PAY) && s_axis_tvalid && s_axis_tready;
    assign w_pay_k       = r_pay_cnt + 8'd1;

    // Early tlast (count short of LEN) or LEN reached without tlast.
    assign frame_err = w_pay_acc &&
                       (s_axis_tlast ? (w_pay_k != r_len) : (w_pay_k == r_len));

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;

    assign w_tot_len = 16'd32 + {8'd0, r_len};
    assign w_udp_len = 16'd12 + {8'd0, r_len};

`ifdef UDP_TX_IP_CSUM_EN
    logic [15:0] w_cmd_tot_len;
    logic [19:0] w_sum;
    logic [16:0] w_fold1;
    logic [15:0] w_fold2;
    logic [15:0] r_csum;

    // Only total length varies per frame; every other header word is fixed.
    assign w_cmd_tot_len = 16'd32 + {8'd0, cmd_len};
    assign w_sum   = 20'h04500 + {4'd0, w_cmd_tot_len} + {4'd0, TTL, 8'h11}
                   + {4'd0, SRC_IP[31:16]} + {4'd0, SRC_IP[15:0]}
                   + {4'd0, DST_IP[31:16]} + {4'd0, DST_IP[15:0]};
    assign w_fold1 = {1'b0, w_sum[15:0]} + {13'd0, w_sum[19:16]};
    assign w_fold2 = w_fold1[15:0] + {15'd0, w_fold1[16]};

    // Capture the checksum with the command so the header never sees live inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_csum <= 16'h0000;
        end else if (cmd_valid && cmd_ready) begin
            r_csum <= ~w_fold2;
        end
    end

    assign w_csum = r_csum;
`else
    assign w_csum = 16'h0000;
`endif

    // Bytes 0..44 of the frame, MSB = byte 0.
    assign w_hdr = {DST_MAC, SRC_MAC, 16'h0800,
                    8'h45, 8'h00, w_tot_len, 32'h0000_0000, TTL, 8'h11, w_csum,
                    SRC_IP, DST_IP,
                    SRC_PORT, r_dst_port, w_udp_len, 16'h0000,
                    8'hAA, 8'h55, r_len};
    assign w_bit_idx  = c_HDR_MSB - {r_cnt, 3'b000};
    assign w_hdr_byte = w_hdr[w_bit_idx -: 8];

    // Frame sequencer and registered output slice.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 6'd0;
            r_len      <= 8'h00;
            r_dst_port <= 16'h0000;
            r_pay_cnt  <= 8'h00;
            r_chk      <= 8'h00;
            r_drain    <= 1'b0;
            r_chk_sent <= 1'b0;
            r_tdata    <= 8'h00;
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
        end else begin
            // A consumed byte leaves the slice empty unless reloaded below.
            if (r_tvalid && m_axis_tready) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    // Slice is always empty here, so byte 0 goes out immediately.
                    if (cmd_valid) begin
                        r_len      <= cmd_len;
                        r_dst_port <= cmd_dst_port;
                        r_pay_cnt  <= 8'h00;
                        r_chk      <= 8'h00;
                        r_drain    <= 1'b0;
                        r_chk_sent <= 1'b0;
                        r_cnt      <= 6'd1;
                        r_tdata    <= DST_MAC[47:40];
                        r_tvalid   <= 1'b1;
                        r_tlast    <= 1'b0;
                        r_state    <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (w_load) begin
                        r_tdata  <= w_hdr_byte;
                        r_tvalid <= 1'b1;
                        if (r_cnt == c_LAST_HDR) begin
                            r_state <= (r_len == 8'h00) ? S_CHK : S_PAY;
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                end
                S_PAY: begin
                    if (w_pay_acc) begin
                        r_tdata   <= s_axis_tdata;
                        r_tvalid  <= 1'b1;
                        r_chk     <= r_chk ^ s_axis_tdata;
                        r_pay_cnt <= w_pay_k;
                        if (s_axis_tlast) begin
                            r_state <= (w_pay_k == r_len) ? S_CHK : S_PAD;
                        end else if (w_pay_k == r_len) begin
                            r_drain <= 1'b1;
                            r_state <= S_CHK;
                        end
                    end
                end
                S_PAD: begin
                    if (w_load) begin
                        r_tdata   <= 8'h00;
                        r_tvalid  <= 1'b1;
                        r_pay_cnt <= w_pay_k;
                        if (w_pay_k == r_len) begin
                            r_state <= S_CHK;
                        end
                    end
                end
                S_CHK: begin
                    if (!r_chk_sent) begin
                        if (w_load) begin
                            r_tdata    <= r_chk;
                            r_tvalid   <= 1'b1;
                            r_tlast    <= 1'b1;
                            r_chk_sent <= 1'b1;
                        end
                    end else if (m_axis_tready) begin
                        r_state <= r_drain ? S_DRAIN : S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (s_axis_tvalid && s_axis_tlast) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_udp_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_udp_tx_framer
// Description : Self-checking bench for udp_tx_framer. Expected frames are
//               assembled byte by byte from the frame layout rules and compared
//               against every accepted output byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_udp_tx_framer;

    localparam logic [47:0] c_SRC_MAC  = 48'h02_00_00_00_00_01;
    localparam logic [47:0] c_DST_MAC  = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [31:0] c_SRC_IP   = 32'hC0A8_0001;
    localparam logic [31:0] c_DST_IP   = 32'hC0A8_0002;
    localparam logic [15:0] c_SRC_PORT = 16'h04D2;
    localparam logic [7:0]  c_TTL      = 8'h40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_len;
    logic [15:0] cmd_dst_port;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic        frame_err;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];
    logic        exp_last_q[$];
    int          exp_err;
    logic [7:0]  pay[0:299];
    logic [7:0]  rx[0:511];
    logic [7:0]  ref_rx[0:511];
    int          rx_cnt = 0;
    int          err_cnt = 0;
    int          cyc = 0;
    int          t_acc = -1;
    int          t_first = -1;
    int          t_last = -1;
    bit          bp_mode = 1'b0;
    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic        prev_l = 1'b0;
    logic [7:0]  prev_d = 8'h00;

    always #5 clk = ~clk;

    udp_tx_framer u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_len       (cmd_len),
        .cmd_dst_port  (cmd_dst_port),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .frame_err     (frame_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Ones-complement sum of the ten header words, folded until no carry remains.
    function automatic logic [15:0] ip_csum(input logic [15:0] tot);
`ifdef UDP_TX_IP_CSUM_EN
        logic [15:0] w[10];
        int unsigned s;
        w = '{16'h4500, tot, 16'h0000, 16'h0000, {c_TTL, 8'h11}, 16'h0000,
              c_SRC_IP[31:16], c_SRC_IP[15:0], c_DST_IP[31:16], c_DST_IP[15:0]};
        s = 0;
        for (int i = 0; i < 10; i++) s = s + w[i];
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        return 16'(~s);
`else
        return tot & 16'h0000;
`endif
    endfunction

    task automatic build_expected(input int n, input logic [15:0] dst, input int m);
        logic [7:0]  f[$];
        logic [47:0] mac;
        logic [31:0] ip;
        logic [15:0] tot, ulen, cs;
        logic [7:0]  chk, b;
        tot  = 16'(32 + n);
        ulen = 16'(12 + n);
        cs   = ip_csum(tot);
        mac = c_DST_MAC; for (int i = 5; i >= 0; i--) f.push_back(mac[8*i +: 8]);
        mac = c_SRC_MAC; for (int i = 5; i >= 0; i--) f.push_back(mac[8*i +: 8]);
        f.push_back(8'h08); f.push_back(8'h00);
        f.push_back(8'h45); f.push_back(8'h00);
        f.push_back(tot[15:8]); f.push_back(tot[7:0]);
        for (int i = 0; i < 4; i++) f.push_back(8'h00);
        f.push_back(c_TTL); f.push_back(8'h11);
        f.push_back(cs[15:8]); f.push_back(cs[7:0]);
        ip = c_SRC_IP; for (int i = 3; i >= 0; i--) f.push_back(ip[8*i +: 8]);
        ip = c_DST_IP; for (int i = 3; i >= 0; i--) f.push_back(ip[8*i +: 8]);
        f.push_back(c_SRC_PORT[15:8]); f.push_back(c_SRC_PORT[7:0]);
        f.push_back(dst[15:8]); f.push_back(dst[7:0]);
        f.push_back(ulen[15:8]); f.push_back(ulen[7:0]);
        f.push_back(8'h00); f.push_back(8'h00);
        f.push_back(8'hAA); f.push_back(8'h55); f.push_back(8'(n));
        chk = 8'h00;
        for (int i = 0; i < n; i++) begin
            b = (i < m) ? pay[i] : 8'h00;
            chk = chk ^ b;
            f.push_back(b);
        end
        f.push_back(chk);
        exp_q.delete();
        exp_last_q.delete();
        foreach (f[i]) begin
            exp_q.push_back(f[i]);
            exp_last_q.push_back(i == f.size() - 1);
        end
        exp_err = (m != n) ? 1 : 0;
    endtask

    // Random downstream backpressure when enabled.
    always @(posedge clk) begin
        #1;
        m_axis_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: scoreboard, hold-stability, error pulses and timing marks.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                check("hold_valid", 32'(m_axis_tvalid), 32'd1);
                check("hold_data", {23'd0, m_axis_tlast, m_axis_tdata}, {23'd0, prev_l, prev_d});
            end
            if (frame_err) err_cnt++;
            if (cmd_valid && cmd_ready) t_acc = cyc;
            if (m_axis_tvalid && t_first < 0 && t_acc >= 0) t_first = cyc;
            if (m_axis_tvalid && m_axis_tlast && t_last < 0 && t_acc >= 0) t_last = cyc;
            if (m_axis_tvalid && m_axis_tready) begin
                if (rx_cnt < 512) rx[rx_cnt] = m_axis_tdata;
                rx_cnt++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL extra_byte: got 0x%0h, expected no byte", m_axis_tdata);
                end else begin
                    check("out_byte", 32'(m_axis_tdata), 32'(exp_q.pop_front()));
                    check("out_tlast", 32'(m_axis_tlast), 32'(exp_last_q.pop_front()));
                end
            end
            prev_v = m_axis_tvalid;
            prev_r = m_axis_tready;
            prev_d = m_axis_tdata;
            prev_l = m_axis_tlast;
        end
    end

    task automatic issue_cmd(input int n, input logic [15:0] dst);
        int budget = 0;
        @(negedge clk);
        while (!cmd_ready && budget < 2000) begin @(negedge clk); budget++; end
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_len = 8'(n); cmd_dst_port = dst;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_len = 8'($urandom); cmd_dst_port = 16'($urandom);
    endtask

    task automatic feed_payload(input int n, input int m, input bit gaps);
        int budget;
        bit timeout = 1'b0;
        for (int i = 0; i < m; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                s_axis_tvalid = 1'b0; @(posedge clk); #1;
            end
            s_axis_tdata = pay[i]; s_axis_tvalid = 1'b1; s_axis_tlast = (i == m - 1);
            budget = 0;
            @(negedge clk);
            while (!s_axis_tready && budget < 5000) begin @(negedge clk); budget++; end
            if (budget >= 5000) begin
                check("payload_accept_timeout", 32'd0, 32'd1);
                timeout = 1'b1;
                break;
            end
            if (m > n && i == m - 1) check("drain_cmd_ready_low", 32'(cmd_ready), 32'd0);
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        if (m > n && !timeout) begin
            @(negedge clk);
            check("drain_cmd_ready_high", 32'(cmd_ready), 32'd1);
        end
    endtask

    task automatic send_frame(input int n, input logic [15:0] dst, input int m,
                              input bit gaps, input bit timing_chk);
        int budget = 0;
        build_expected(n, dst, m);
        err_cnt = 0; rx_cnt = 0; t_acc = -1; t_first = -1; t_last = -1;
        issue_cmd(n, dst);
        feed_payload(n, m, gaps);
        while ((exp_q.size() != 0 || !cmd_ready) && budget < 5000) begin
            @(negedge clk); budget++;
        end
        check("frame_complete", 32'(exp_q.size()), 32'd0);
        check("frame_cmd_ready", 32'(cmd_ready), 32'd1);
        check("frame_length", 32'(rx_cnt), 32'(46 + n));
        check("frame_err_count", 32'(err_cnt), 32'(exp_err));
        check("first_byte_latency", 32'(t_first - t_acc), 32'd1);
        if (timing_chk) check("chk_latency", 32'(t_last - t_acc), 32'(46 + n));
        exp_q.delete(); exp_last_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected end of test");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int diffs, n, m, mode, budget;
        logic [7:0] x;
        rst_n = 1'b0; cmd_valid = 1'b1; cmd_len = 8'h05; cmd_dst_port = 16'h1111;
        s_axis_tdata = 8'h00; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1; cmd_valid = 1'b0;
        @(negedge clk);
        // Reset state; the command offered during reset must not have started a frame.
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tlast", 32'(m_axis_tlast), 32'd0);
        check("rst_tdata", 32'(m_axis_tdata), 32'd0);
        check("rst_s_tready", 32'(s_axis_tready), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_frame_err", 32'(frame_err), 32'd0);

        // Single-byte frame with literal pins.
        pay[0] = 8'hBB;
        send_frame(1, 16'h04D2, 1, 1'b0, 1'b1);
        check("ethertype", {16'd0, rx[12], rx[13]}, 32'h0800);
        check("ip_proto", 32'(rx[23]), 32'h11);
        check("ip_total_len", {16'd0, rx[16], rx[17]}, 32'h0021);
        check("udp_dst_len", {rx[36], rx[37], rx[38], rx[39]}, 32'h04D2_000D);
        check("payload_1", {rx[42], rx[43], rx[44], rx[45]}, 32'hAA55_01BB);
        check("chk_1", 32'(rx[46]), 32'hBB);
`ifdef UDP_TX_IP_CSUM_EN
        check("ip_csum", {16'd0, rx[24], rx[25]}, 32'hF978);
`else
        check("ip_csum", {16'd0, rx[24], rx[25]}, 32'h0000);
`endif

        // Three-byte payload, then parse it back per the payload protocol.
        pay[0] = 8'h12; pay[1] = 8'h34; pay[2] = 8'h56;
        send_frame(3, 16'h04D2, 3, 1'b0, 1'b1);
        check("chk_3", 32'(rx[48]), 32'h70);
        check("parse_port", {16'd0, rx[36], rx[37]}, 32'h04D2);
        check("parse_sync", {16'd0, rx[42], rx[43]}, 32'hAA55);
        x = 8'h00;
        for (int i = 0; i < 3; i++) x = x ^ rx[45 + i];
        check("parse_chk_ok", 32'(x), 32'(rx[45 + 3]));
        check("parse_data", {8'd0, rx[45], rx[46], rx[47]}, 32'h0012_3456);

        // Backpressure: same sequence as the unthrottled run.
        for (int i = 0; i < 10; i++) pay[i] = 8'($urandom);
        send_frame(10, 16'hBEEF, 10, 1'b0, 1'b1);
        for (int i = 0; i < 56; i++) ref_rx[i] = rx[i];
        bp_mode = 1'b1;
        send_frame(10, 16'hBEEF, 10, 1'b0, 1'b0);
        bp_mode = 1'b0;
        diffs = 0;
        for (int i = 0; i < 56; i++) if (rx[i] !== ref_rx[i]) diffs++;
        check("bp_same_sequence", 32'(diffs), 32'd0);

        // Early tlast: padded with zero.
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
        send_frame(4, 16'h04D2, 3, 1'b0, 1'b1);
        check("early_data", {rx[45], rx[46], rx[47], rx[48]}, 32'h0102_0300);
        check("early_chk", 32'(rx[49]), 32'h00);

        // Missing tlast: truncated, excess drained.
        pay[0] = 8'h0A; pay[1] = 8'h0B; pay[2] = 8'h0C; pay[3] = 8'h0D;
        send_frame(2, 16'h04D2, 4, 1'b0, 1'b1);
        check("missing_data", {16'd0, rx[45], rx[46]}, 32'h0A0B);
        check("missing_chk", 32'(rx[47]), 32'h01);

        // Empty payload.
        send_frame(0, 16'h0050, 0, 1'b0, 1'b1);
        check("empty_tail", {rx[42], rx[43], rx[44], rx[45]}, 32'hAA55_0000);

        // Mid-frame reset around byte 20, then a clean frame.
        for (int i = 0; i < 5; i++) pay[i] = 8'($urandom);
        build_expected(5, 16'h1234, 5);
        rx_cnt = 0; t_acc = -1; t_first = -1; t_last = -1;
        issue_cmd(5, 16'h1234);
        budget = 0;
        while (rx_cnt < 20 && budget < 200) begin @(negedge clk); budget++; end
        check("reach_byte_20", 32'(rx_cnt >= 20), 32'd1);
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        check("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        exp_q.delete(); exp_last_q.delete();
        send_frame(5, 16'h1234, 5, 1'b0, 1'b1);

        // Randomized frames: normal, early tlast, missing tlast, throttled or not.
        for (int k = 0; k < 14; k++) begin
            bit bp, gaps;
            n = $urandom_range(0, 40);
            mode = (n == 0) ? 0 : $urandom_range(0, 2);
            if (mode == 1 && n < 2) mode = 0;
            case (mode)
                1:       m = $urandom_range(1, n - 1);
                2:       m = n + $urandom_range(1, 3);
                default: m = n;
            endcase
            for (int i = 0; i < m; i++) pay[i] = 8'($urandom);
            bp   = 1'($urandom_range(0, 1));
            gaps = 1'($urandom_range(0, 1));
            bp_mode = bp;
            send_frame(n, 16'($urandom), m, gaps, !bp && !gaps);
            bp_mode = 1'b0;
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/udp_tx_framer.md
# udp_tx_framer

Transmit-side counterpart of the receive path (UDP port filter → async FIFO → packet parser) on the application clock. It takes a per-frame command and a payload byte stream, and emits one complete Ethernet/IPv4/UDP frame as an AXI-Stream byte stream. The UDP payload uses the parser protocol: `AA 55 LEN DATA[0..LEN-1] CHK`, where CHK is the XOR of the DATA bytes. Its output feeds the MAC TX path, and its frames are accepted unchanged by the receive chain when the destination port matches.

## Interface
Parameters:
- SRC_MAC, 48'h02_00_00_00_00_01, Ethernet source address
- DST_MAC, 48'hFF_FF_FF_FF_FF_FF, Ethernet destination address
- SRC_IP, 32'hC0A8_0001, IPv4 source address
- DST_IP, 32'hC0A8_0002, IPv4 destination address
- SRC_PORT, 16'h04D2, UDP source port
- TTL, 8'h40, IPv4 time-to-live

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  frame request valid
- cmd_ready  out  1  high only in IDLE
- cmd_len  in  8  payload length N (0..255)
- cmd_dst_port  in  16  UDP destination port
- s_axis_tdata  in  8  payload byte
- s_axis_tvalid  in  1  payload valid
- s_axis_tlast  in  1  last payload byte
- s_axis_tready  out  1  payload accept
- m_axis_tdata  out  8  frame byte
- m_axis_tvalid  out  1  frame byte valid
- m_axis_tlast  out  1  high on the CHK byte only
- m_axis_tready  in  1  downstream accept
- frame_err  out  1  one-cycle pulse on a length/tlast mismatch

## Operation
- Command capture: the command is accepted on cycle T when cmd_valid && cmd_ready. At that cycle the block latches N and dst_port and registers the IPv4 checksum.
- Frame layout: the frame is 46+N bytes, in this byte order:
  - Bytes 0–11: DST_MAC, then SRC_MAC, MSB first.
  - Bytes 12–13: 08 00.
  - Bytes 14–33: IPv4 header, in order: 45, 00, total length (16 bits), 00 00, 00 00, TTL, 11, checksum (16 bits), SRC_IP, DST_IP.
  - Bytes 34–41: UDP header, in order: SRC_PORT, dst_port, UDP length (16 bits), 00 00.
  - Bytes 42–44: AA, 55, N.
  - Next N bytes: DATA.
  - Last byte: CHK.
- Length fields: all arithmetic is 16-bit unsigned. IPv4 total length = 32+N. UDP length = 12+N.
- States: IDLE → HDR (counter 0..44) → PAY (N bytes; skipped when N=0) → CHK → IDLE.
  - PAD is inserted after PAY when tlast arrives early.
  - DRAIN follows CHK when tlast is missing.
- PAY: each input byte accepted is forwarded and XORed into CHK. s_axis_tready = (state==PAY) && (!m_axis_tvalid || m_axis_tready).
- Early tlast (tlast accepted on byte k < N):
  - frame_err pulses on the cycle that byte is accepted.
  - PAD emits N−k bytes of 00 (CHK unaffected); then CHK.
- Missing tlast (byte N accepted without tlast):
  - frame_err pulses on that cycle.
  - After CHK is accepted, DRAIN holds s_axis_tready=1 and discards input through the tlast byte, then goes to IDLE.
- N=0: frame is `AA 55 00 00`, 46 bytes total. No payload bytes are consumed unless DRAIN applies.
- Payload must not be presented before its command; s_axis_tready is 0 outside PAY and DRAIN.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=00, s_axis_tready=0, cmd_ready=1, frame_err=0, state=IDLE, CHK=00.
- Reset applied mid-frame: all of the above take effect the next edge. The partial frame is abandoned with no tlast.
- Output is a registered slice, loaded when !m_axis_tvalid || m_axis_tready. tdata and tlast hold while tvalid && !tready.
- Latency: first byte valid on cycle T+1.
- Throughput: with tready=1 and payload always valid, one byte per cycle with no bubbles, so the CHK byte is valid at T+46+N.
- cmd_ready returns high the cycle after the CHK byte is accepted (after DRAIN when applicable), giving one idle cycle minimum between frames.
- Simultaneous cmd_valid and reset: reset wins and the command is not accepted.

## Configuration
- `UDP_TX_IP_CSUM_EN` defined:
  - Bytes 24–25 carry the IPv4 header checksum: the ones-complement of the ones-complement sum of the ten header words, with carries folded twice.
  - The checksum is computed combinationally from N at command accept and registered.
- Undefined: bytes 24–25 are 00 00 and no checksum logic is built.

## Test plan
- Single-byte frame: cmd_len=1, dst=04D2, payload BB with tlast, tready=1, default parameters.
  - 47 bytes out; bytes 12–13 = 08 00; byte 23 = 11; bytes 16–17 = 00 21.
  - Bytes 36–39 = 04 D2 00 0D; bytes 42–46 = AA 55 01 BB BB; tlast on byte 46 only.
  - Bytes 24–25 = F9 78 with the macro defined, 00 00 without.
- Multi-byte payload: cmd_len=3, payload 12 34 56 → CHK=70, 49 bytes; looped back through the UDP filter and parser with dst=04D2, the parser outputs 12 34 56 with no error.
- Backpressure: random m_axis_tready (50%) with a 10-byte payload → output byte sequence identical to the tready=1 run; tdata stable whenever tvalid && !tready.
- Early tlast: cmd_len=4, payload 01 02 03 with tlast on 03 → DATA 01 02 03 00, CHK=00, frame_err pulses once.
- Missing tlast: cmd_len=2, payload 0A 0B 0C 0D with tlast on 0D → DATA 0A 0B, CHK=01, frame_err pulses once; 0C and 0D are dropped; cmd_ready rises only after 0D is consumed.
- Mid-frame reset: rst_n low for one cycle at byte 20 → next cycle m_axis_tvalid=0 and cmd_ready=1; the next command produces a complete, correct frame.
